// File: rtl/divider.sv
// -----------------------------------------------------------------------------
// divider
//   Sequential signed fixed-point divider, val = a / b. Operands and result are
//   two's-complement Q(WIDTH-FBITS).FBITS. Magnitudes are divided by a
//   restoring divider producing one quotient bit per clock, MSB first, and the
//   sign is applied in a final cycle. The result is truncated toward zero.
//
// Ports
//   clk_in  in   1      clock, all logic on the rising edge
//   rst_in  in   1      synchronous active-high reset, aborts a running division
//   start   in   1      request a division, sampled only while idle
//   busy    out  1      division in progress
//   done    out  1      one-cycle pulse when a division finishes (any outcome)
//   valid   out  1      val holds a correct quotient
//   dbz     out  1      last division had b == 0
//   ovf     out  1      last quotient does not fit in WIDTH signed bits
//   a       in   WIDTH  dividend
//   b       in   WIDTH  divisor
//   val     out  WIDTH  quotient
// -----------------------------------------------------------------------------
module divider #(
  parameter int WIDTH = 16,
  parameter int FBITS = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             valid,
  output logic             dbz,
  output logic             ovf,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] val
);

  // Dividend is |a| scaled by 2^FBITS, so the quotient needs NB bits.
  localparam int NB = WIDTH + FBITS;
  localparam int CW = $clog2(NB + 1);

  typedef enum logic [1:0] {IDLE, CALC, SIGN} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [NB-1:0]    dvd_q,   dvd_d;    // dividend shifts out, quotient shifts in
  logic [WIDTH-1:0] rem_q,   rem_d;
  logic [WIDTH-1:0] ub_q,    ub_d;
  logic             neg_q,   neg_d;
  logic             done_q,  done_d;
  logic             valid_q, valid_d;
  logic             dbz_q,   dbz_d;
  logic             ovf_q,   ovf_d;
  logic [WIDTH-1:0] val_q,   val_d;

  // Restoring step: bring in the next dividend bit, subtract when it fits.
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_diff;
  logic             take;
  // Unsigned magnitudes; -2^(WIDTH-1) maps exactly to 2^(WIDTH-1).
  logic [WIDTH-1:0] ua;
  logic [WIDTH-1:0] ub;
  logic [WIDTH-1:0] q_lo;

  assign rem_sh   = {rem_q, dvd_q[NB-1]};
  assign rem_diff = rem_sh - {1'b0, ub_q};
  assign take     = (rem_sh >= {1'b0, ub_q});
  assign ua       = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
  assign ub       = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
  assign q_lo     = dvd_q[WIDTH-1:0];

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    ub_d    = ub_q;
    neg_d   = neg_q;
    done_d  = 1'b0;
    valid_d = valid_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    val_d   = val_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          valid_d = 1'b0;
          dbz_d   = 1'b0;
          ovf_d   = 1'b0;
          val_d   = '0;
          if (b == '0) begin
            // Divide-by-zero completes immediately without leaving IDLE.
            dbz_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            state_d = CALC;
            cnt_d   = '0;
            dvd_d   = NB'(ua) << FBITS;
            rem_d   = '0;
            ub_d    = ub;
            neg_d   = a[WIDTH-1] ^ b[WIDTH-1];
          end
        end
      end

      CALC: begin
        rem_d = take ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        dvd_d = (dvd_q << 1) | NB'(take);
        if (cnt_q == CW'(NB - 1)) begin
          state_d = SIGN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      SIGN: begin
        state_d = IDLE;
        done_d  = 1'b1;
        // Any bit at or above WIDTH-1 means |q| >= 2^(WIDTH-1); the most
        // negative value is also rejected to keep the range symmetric.
        if (|dvd_q[NB-1:WIDTH-1]) begin
          ovf_d   = 1'b1;
          valid_d = 1'b0;
          val_d   = '0;
        end else begin
          valid_d = 1'b1;
          val_d   = neg_q ? (~q_lo + WIDTH'(1)) : q_lo;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      rem_q   <= '0;
      ub_q    <= '0;
      neg_q   <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
      val_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      ub_q    <= ub_d;
      neg_q   <= neg_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
      val_q   <= val_d;
    end
  end

  assign busy  = (state_q != IDLE);
  assign done  = done_q;
  assign valid = valid_q;
  assign dbz   = dbz_q;
  assign ovf   = ovf_q;
  assign val   = val_q;

endmodule

// File: tb/tb_divider.sv
// -----------------------------------------------------------------------------
// tb_divider
//   Table-driven bench for divider (WIDTH=16, FBITS=8). Each accepted request
//   pushes its expected outcome onto a scoreboard queue; a monitor pops and
//   compares on every done pulse, including completion latency. Hand-written
//   sequences cover start-while-busy, reset mid-division and back-to-back.
// -----------------------------------------------------------------------------
module tb_divider;

  localparam int WIDTH = 16;
  localparam int FBITS = 8;
  localparam int LAT   = WIDTH + FBITS + 1;  // edges from accept edge to done edge

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] val;
    logic        valid;
    logic        dbz;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [15:0] val;
    logic        valid;
    logic        dbz;
    logic        ovf;
    int          acc_cyc;
    int          lat;
  } sb_t;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        start;
  logic        busy, done, valid, dbz, ovf;
  logic [15:0] a, b, val;

  int  n_vec = 0;
  int  n_bad = 0;
  int  cyc_cnt = 0;
  sb_t sb_q[$];
  sb_t sb_e;
  vec_t vecs[15];

  divider #(.WIDTH(WIDTH), .FBITS(FBITS)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .start  (start),
    .busy   (busy),
    .done   (done),
    .valid  (valid),
    .dbz    (dbz),
    .ovf    (ovf),
    .a      (a),
    .b      (b),
    .val    (val)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expectation.
  always @(negedge clk_in) begin
    if (done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        sb_e = sb_q.pop_front();
        check("val",     32'(val),   32'(sb_e.val));
        check("valid",   32'(valid), 32'(sb_e.valid));
        check("dbz",     32'(dbz),   32'(sb_e.dbz));
        check("ovf",     32'(ovf),   32'(sb_e.ovf));
        check("latency", 32'(cyc_cnt - sb_e.acc_cyc), 32'(sb_e.lat));
        check("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  // Called #1 after the accept edge.
  task automatic push_exp(input vec_t v);
    sb_t e;
    e.val     = v.val;
    e.valid   = v.valid;
    e.dbz     = v.dbz;
    e.ovf     = v.ovf;
    e.acc_cyc = cyc_cnt;
    e.lat     = v.dbz ? 0 : LAT;
    sb_q.push_back(e);
  endtask

  // Waits (bounded) for done; busy must stay high in every cycle before it.
  task automatic wait_done(input string tag);
    bit seen    = 0;
    bit busy_ok = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_in);
      if (done) begin
        seen = 1;
        break;
      end
      if (!busy) busy_ok = 0;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_busy_held"}, 32'(busy_ok), 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    @(negedge clk_in);
    a = v.a;
    b = v.b;
    start = 1'b1;
    @(posedge clk_in);
    #1;
    push_exp(v);
    start = 1'b0;
    wait_done(tag);
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"},  32'(busy),  32'd0);
    check({tag, "_done"},  32'(done),  32'd0);
    check({tag, "_valid"}, 32'(valid), 32'd0);
    check({tag, "_dbz"},   32'(dbz),   32'd0);
    check({tag, "_ovf"},   32'(ovf),   32'd0);
    check({tag, "_val"},   32'(val),   32'd0);
  endtask

  initial begin
    //          a        b        val      valid dbz  ovf
    vecs[0]  = '{16'h0100, 16'h0080, 16'h0200, 1'b1, 1'b0, 1'b0}; // 1.0/0.5
    vecs[1]  = '{16'h0100, 16'hFF00, 16'hFF00, 1'b1, 1'b0, 1'b0}; // 1.0/-1.0
    vecs[2]  = '{16'h0100, 16'h0300, 16'h0055, 1'b1, 1'b0, 1'b0}; // 1.0/3.0
    vecs[3]  = '{16'h0100, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0}; // b == 0
    vecs[4]  = '{16'h0100, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b1}; // 256.0 overflows
    vecs[5]  = '{16'h8000, 16'h0100, 16'h0000, 1'b0, 1'b0, 1'b1}; // -128 rejected
    vecs[6]  = '{16'h7FFF, 16'h0100, 16'h7FFF, 1'b1, 1'b0, 1'b0}; // max positive
    vecs[7]  = '{16'h8000, 16'hFF00, 16'h0000, 1'b0, 1'b0, 1'b1}; // +128 overflows
    vecs[8]  = '{16'hFF80, 16'h0300, 16'hFFD6, 1'b1, 1'b0, 1'b0}; // -0.5/3 -> -42 lsb
    vecs[9]  = '{16'h0000, 16'h0005, 16'h0000, 1'b1, 1'b0, 1'b0}; // zero dividend
    vecs[10] = '{16'h0100, 16'h8000, 16'hFFFE, 1'b1, 1'b0, 1'b0}; // 1/-128
    vecs[11] = '{16'h8000, 16'h8000, 16'h0100, 1'b1, 1'b0, 1'b0}; // -128/-128
    vecs[12] = '{16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0}; // 0/0
    vecs[13] = '{16'h7FFF, 16'h7FFF, 16'h0100, 1'b1, 1'b0, 1'b0}; // x/x
    vecs[14] = '{16'hFFFF, 16'h0100, 16'hFFFF, 1'b1, 1'b0, 1'b0}; // -1 lsb / 1.0

    rst_in = 1'b1;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    repeat (3) @(negedge clk_in);
    check_idle_zero("reset");
    rst_in = 1'b0;

    for (int i = 0; i < 15; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // start pulsed mid-division with new operands: ignored.
    @(negedge clk_in);
    a = 16'h0100;
    b = 16'h0080;
    start = 1'b1;
    @(posedge clk_in);
    #1;
    push_exp(vecs[0]);
    start = 1'b0;
    repeat (5) @(negedge clk_in);
    a = 16'h0100;
    b = 16'h0001;
    start = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
    a = 16'h1234;
    b = 16'h0000;
    wait_done("ignore_start");
    repeat (4) @(negedge clk_in);

    // Reset mid-division: outputs cleared, no done pulse afterwards.
    @(negedge clk_in);
    a = 16'h0100;
    b = 16'h0300;
    start = 1'b1;
    @(posedge clk_in);
    #1;
    start = 1'b0;
    repeat (10) @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    check_idle_zero("midreset");
    rst_in = 1'b0;
    repeat (30) @(negedge clk_in);
    check("midreset_sb_empty", 32'(sb_q.size()), 32'd0);
    run_vec(vecs[2], "after_reset");

    // Back-to-back: start held high, second accept in the done cycle.
    @(negedge clk_in);
    a = vecs[0].a;
    b = vecs[0].b;
    start = 1'b1;
    @(posedge clk_in);
    #1;
    push_exp(vecs[0]);
    a = vecs[1].a;
    b = vecs[1].b;
    wait_done("b2b_first");
    @(posedge clk_in);
    #1;
    push_exp(vecs[1]);
    start = 1'b0;
    wait_done("b2b_second");

    repeat (4) @(negedge clk_in);
    check("final_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
